// File: rtl/comp_fetch_ctrl_if.sv
// rtl/comp_fetch_ctrl_if.sv - core fetch and cache request/response bundle for comp_fetch_ctrl
interface comp_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CW     = 16
);
  logic              proc_valid;
  logic [ADDR_W-1:0] proc_addr;
  logic              proc_ready;
  logic [31:0]       proc_rdata;
  logic              ic_valid;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [31:0]       ic_rdata;
  logic              cc_valid;
  logic [ADDR_W-1:0] cc_addr;
  logic              cc_hit;
  logic [CW-1:0]     cc_rdata;
  logic              cc_fill_valid;
  logic [ADDR_W-1:0] cc_fill_addr;
  logic [CW-1:0]     cc_fill_data;

  modport master (
    input  proc_valid, proc_addr, ic_ready, ic_rdata, cc_hit, cc_rdata,
    output proc_ready, proc_rdata, ic_valid, ic_addr, cc_valid, cc_addr,
           cc_fill_valid, cc_fill_addr, cc_fill_data
  );

  modport slave (
    output proc_valid, proc_addr, ic_ready, ic_rdata, cc_hit, cc_rdata,
    input  proc_ready, proc_rdata, ic_valid, ic_addr, cc_valid, cc_addr,
           cc_fill_valid, cc_fill_addr, cc_fill_data
  );
endinterface

// File: rtl/comp_fetch_ctrl.sv
// rtl/comp_fetch_ctrl.sv - compressed-first fetch controller with dictionary refill
// Optional saturating statistics counters: COMP_FETCH_CTRL_STATS_EN.
module comp_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int K1_W   = 3,
  parameter int K2_W   = 8,
  parameter int K3_W   = 5,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  comp_fetch_ctrl_if.master bus,
  output logic [K1_W-1:0]   dec_key1,
  output logic [K2_W-1:0]   dec_key2,
  output logic [K3_W-1:0]   dec_key3,
  input  logic [6:0]        dec_val1,
  input  logic [14:0]       dec_val2,
  input  logic [9:0]        dec_val3,
  output logic [6:0]        enc_val1,
  output logic [14:0]       enc_val2,
  output logic [9:0]        enc_val3,
  input  logic              enc_hit1,
  input  logic              enc_hit2,
  input  logic              enc_hit3,
  input  logic [K1_W-1:0]   enc_key1,
  input  logic [K2_W-1:0]   enc_key2,
  input  logic [K3_W-1:0]   enc_key3,
  output logic [STAT_W-1:0] cnt_cc_hit,
  output logic [STAT_W-1:0] cnt_fill,
  output logic [STAT_W-1:0] cnt_nocomp
);
  localparam int CW = K1_W + K2_W + K3_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, IC_REQ, ENC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic [CW-1:0]     keys_q;
  logic              fill_ok_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.proc_ready    = 1'b0;
    bus.cc_valid      = 1'b0;
    bus.ic_valid      = 1'b0;
    bus.cc_fill_valid = 1'b0;
    case (state_q)
      IDLE:    if (bus.proc_valid) state_d = LOOKUP;
      LOOKUP: begin
        bus.cc_valid = 1'b1;
        state_d      = bus.cc_hit ? RESP : IC_REQ;
      end
      IC_REQ: begin
        bus.ic_valid = 1'b1;
        if (bus.ic_ready) state_d = ENC;
      end
      ENC:     state_d = RESP;
      RESP: begin
        bus.proc_ready    = 1'b1;
        // fill_ok_q is only ever set on the refill path
        bus.cc_fill_valid = fill_ok_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdata_q is loaded only on the transition into RESP so it holds between responses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      word_q    <= '0;
      rdata_q   <= '0;
      keys_q    <= '0;
      fill_ok_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.proc_valid) begin
          addr_q    <= bus.proc_addr;
          fill_ok_q <= 1'b0;
        end
        LOOKUP: if (bus.cc_hit)
          rdata_q <= {dec_val3[9:3], dec_val2[14:5], dec_val3[2:0], dec_val2[4:0], dec_val1};
        IC_REQ: if (bus.ic_ready) word_q <= bus.ic_rdata;
        ENC: begin
          rdata_q   <= word_q;
          fill_ok_q <= enc_hit1 & enc_hit2 & enc_hit3;
          keys_q    <= {enc_key3, enc_key2, enc_key1};
        end
        default: ;
      endcase
    end
  end

  assign bus.cc_addr      = addr_q;
  assign bus.ic_addr      = addr_q;
  assign bus.proc_rdata   = rdata_q;
  assign bus.cc_fill_addr = addr_q;
  assign bus.cc_fill_data = keys_q;

  assign dec_key1 = bus.cc_rdata[K1_W-1:0];
  assign dec_key2 = bus.cc_rdata[K1_W+K2_W-1:K1_W];
  assign dec_key3 = bus.cc_rdata[CW-1:K1_W+K2_W];

  assign enc_val1 = word_q[6:0];
  assign enc_val2 = {word_q[24:15], word_q[11:7]};
  assign enc_val3 = {word_q[31:25], word_q[14:12]};

`ifdef COMP_FETCH_CTRL_STATS_EN
  logic [STAT_W-1:0] hit_q, fill_q, nocomp_q;
  logic              refill_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q    <= '0;
      fill_q   <= '0;
      nocomp_q <= '0;
      refill_q <= 1'b0;
    end else begin
      if (state_q == IDLE) refill_q <= 1'b0;
      if (state_q == ENC)  refill_q <= 1'b1;
      if (state_q == LOOKUP && bus.cc_hit && hit_q != '1) hit_q <= hit_q + 1'b1;
      if (bus.cc_fill_valid && fill_q != '1) fill_q <= fill_q + 1'b1;
      if (state_q == RESP && refill_q && !fill_ok_q && nocomp_q != '1)
        nocomp_q <= nocomp_q + 1'b1;
    end
  end

  assign cnt_cc_hit = hit_q;
  assign cnt_fill   = fill_q;
  assign cnt_nocomp = nocomp_q;
`else
  assign cnt_cc_hit = '0;
  assign cnt_fill   = '0;
  assign cnt_nocomp = '0;
`endif
endmodule

// File: tb/tb_comp_fetch_ctrl.sv
// tb/tb_comp_fetch_ctrl.sv - self-checking bench for comp_fetch_ctrl
// Counter expectations follow COMP_FETCH_CTRL_STATS_EN when defined.
module tb_comp_fetch_ctrl;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  comp_fetch_ctrl_if #(.ADDR_W(32), .CW(16)) bus ();

  logic [2:0]  dec_key1;
  logic [7:0]  dec_key2;
  logic [4:0]  dec_key3;
  logic [6:0]  dec_val1;
  logic [14:0] dec_val2;
  logic [9:0]  dec_val3;
  logic [6:0]  enc_val1;
  logic [14:0] enc_val2;
  logic [9:0]  enc_val3;
  logic        enc_hit1, enc_hit2, enc_hit3;
  logic [2:0]  enc_key1;
  logic [7:0]  enc_key2;
  logic [4:0]  enc_key3;
  logic [3:0]  cnt_cc_hit, cnt_fill, cnt_nocomp;

  logic [6:0]  dec_tab1 [8];
  logic [14:0] dec_tab2 [256];
  logic [9:0]  dec_tab3 [32];
  assign dec_val1 = dec_tab1[dec_key1];
  assign dec_val2 = dec_tab2[dec_key2];
  assign dec_val3 = dec_tab3[dec_key3];

  comp_fetch_ctrl #(.ADDR_W(32), .K1_W(3), .K2_W(8), .K3_W(5), .STAT_W(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .dec_key1(dec_key1), .dec_key2(dec_key2), .dec_key3(dec_key3),
    .dec_val1(dec_val1), .dec_val2(dec_val2), .dec_val3(dec_val3),
    .enc_val1(enc_val1), .enc_val2(enc_val2), .enc_val3(enc_val3),
    .enc_hit1(enc_hit1), .enc_hit2(enc_hit2), .enc_hit3(enc_hit3),
    .enc_key1(enc_key1), .enc_key2(enc_key2), .enc_key3(enc_key3),
    .cnt_cc_hit(cnt_cc_hit), .cnt_fill(cnt_fill), .cnt_nocomp(cnt_nocomp)
  );

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] inst;
    int          ic_wait;
    logic [2:0]  ehit;
    logic [2:0]  k1;
    logic [7:0]  k2;
    logic [4:0]  k3;
    logic        exp_fill;
    logic [15:0] exp_fdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        hit;
    logic        fill;
    logic [15:0] fdata;
    logic [6:0]  ev1;
    logic [14:0] ev2;
    logic [9:0]  ev3;
    int          cyc;
  } exp_t;

  exp_t        sb_q [$];
  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  int          ic_wait = 0;
  logic [31:0] ic_inst = '0;
  int          m_hit = 0, m_fill = 0, m_nocomp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void split(input logic [31:0] w, output logic [6:0] f1,
                                output logic [14:0] f2, output logic [9:0] f3);
    f1 = w[6:0];
    f2 = {w[24:15], w[11:7]};
    f3 = {w[31:25], w[14:12]};
  endfunction

  function automatic int sat(input int x);
    return (x >= 15) ? 15 : x + 1;
  endfunction

  // Regular icache: answers after ic_wait stalled cycles
  initial begin
    int wcnt;
    wcnt = 0;
    bus.ic_ready = 1'b0;
    bus.ic_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.ic_ready = 1'b0;
        wcnt = 0;
      end else if (bus.ic_valid && !bus.ic_ready) begin
        if (wcnt == ic_wait) begin
          bus.ic_ready = 1'b1;
          bus.ic_rdata = ic_inst;
        end else wcnt++;
      end else begin
        bus.ic_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Response monitor / scoreboard consumer
  initial begin
    logic ic_seen;
    exp_t e;
    ic_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ic_seen = 1'b0;
      end else begin
        if (bus.ic_valid) ic_seen = 1'b1;
        if (bus.cc_valid && sb_q.size() > 0) chk("cc_addr", bus.cc_addr, sb_q[0].addr);
        if (bus.ic_valid && sb_q.size() > 0) chk("ic_addr", bus.ic_addr, sb_q[0].addr);
        if (bus.cc_fill_valid && !bus.proc_ready) chk("fill_without_resp", 32'd1, 32'd0);
        if (bus.proc_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("rdata", bus.proc_rdata, e.rdata);
            chk("resp_cycle", cyc, e.cyc);
            chk("fill_valid", {31'b0, bus.cc_fill_valid}, {31'b0, e.fill});
            chk("fill_addr", bus.cc_fill_addr, e.addr);
            chk("ic_used", {31'b0, ic_seen}, {31'b0, !e.hit});
            if (e.fill) chk("fill_data", {16'b0, bus.cc_fill_data}, {16'b0, e.fdata});
            if (!e.hit) begin
              chk("enc_val1", {25'b0, enc_val1}, {25'b0, e.ev1});
              chk("enc_val2", {17'b0, enc_val2}, {17'b0, e.ev2});
              chk("enc_val3", {22'b0, enc_val3}, {22'b0, e.ev3});
            end
          end
          resp_cnt++;
          ic_seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_cnt < target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("resp_timeout", {31'b0, resp_cnt >= target}, 32'd1);
  endtask

  task automatic chk_counters();
    chk("cnt_cc_hit", {28'b0, cnt_cc_hit}, m_hit);
    chk("cnt_fill", {28'b0, cnt_fill}, m_fill);
    chk("cnt_nocomp", {28'b0, cnt_nocomp}, m_nocomp);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    logic [6:0]  f1;
    logic [14:0] f2;
    logic [9:0]  f3;
    int target;
    @(negedge clk);
    split(v.inst, f1, f2, f3);
    if (v.hit) begin
      dec_tab1[v.k1] = f1;
      dec_tab2[v.k2] = f2;
      dec_tab3[v.k3] = f3;
      bus.cc_rdata = {v.k3, v.k2, v.k1};
    end
    bus.cc_hit = v.hit;
    ic_inst = v.inst;
    ic_wait = v.ic_wait;
    {enc_hit3, enc_hit2, enc_hit1} = v.ehit;
    enc_key1 = v.k1;
    enc_key2 = v.k2;
    enc_key3 = v.k3;
    e.addr = v.addr;  e.rdata = v.inst;  e.hit = v.hit;
    e.fill = v.exp_fill;  e.fdata = v.exp_fdata;
    e.ev1 = f1;  e.ev2 = f2;  e.ev3 = f3;
    e.cyc = cyc + (v.hit ? 2 : 4 + v.ic_wait);
    sb_q.push_back(e);
`ifdef COMP_FETCH_CTRL_STATS_EN
    if (v.hit) m_hit = sat(m_hit);
    else if (v.exp_fill) m_fill = sat(m_fill);
    else m_nocomp = sat(m_nocomp);
`endif
    target = resp_cnt + 1;
    bus.proc_addr = v.addr;
    bus.proc_valid = 1'b1;
    @(negedge clk);
    bus.proc_valid = 1'b0;
    wait_resp(target);
    @(negedge clk);
    #1;
    chk_counters();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int base;
    int n;
    resetn = 1'b0;
    bus.proc_valid = 1'b0;
    bus.proc_addr = '0;
    bus.cc_hit = 1'b0;
    bus.cc_rdata = '0;
    {enc_hit1, enc_hit2, enc_hit3} = 3'b000;
    enc_key1 = '0; enc_key2 = '0; enc_key3 = '0;
    for (int i = 0; i < 8; i++) dec_tab1[i] = '0;
    for (int i = 0; i < 256; i++) dec_tab2[i] = '0;
    for (int i = 0; i < 32; i++) dec_tab3[i] = '0;

    //          addr      hit   inst          wait ehit    k1    k2     k3      fill  fdata
    vecs[0] = '{32'h100, 1'b1, 32'h00B50513, 0, 3'b000, 3'd2, 8'h15, 5'h07, 1'b0, 16'h0000};
    vecs[1] = '{32'h104, 1'b0, 32'h00000013, 3, 3'b111, 3'd1, 8'h02, 5'h03, 1'b1, 16'h1811};
    vecs[2] = '{32'h108, 1'b0, 32'h00000013, 3, 3'b101, 3'd1, 8'h02, 5'h03, 1'b0, 16'h0000};
    vecs[3] = '{32'h10C, 1'b0, 32'hFEDCBA98, 0, 3'b111, 3'd7, 8'hFF, 5'h1F, 1'b1, 16'hFFFF};
    vecs[4] = '{32'h110, 1'b0, 32'h12345678, 1, 3'b011, 3'd6, 8'h33, 5'h09, 1'b0, 16'h0000};
    vecs[5] = '{32'h114, 1'b1, 32'hDEADBEEF, 0, 3'b000, 3'd5, 8'hA5, 5'h11, 1'b0, 16'h0000};
    vecs[6] = '{32'h118, 1'b0, 32'h0040006F, 2, 3'b111, 3'd4, 8'h80, 5'h10, 1'b1, 16'h8404};

    repeat (2) @(negedge clk);
    chk("rst_proc_ready", {31'b0, bus.proc_ready}, 32'd0);
    chk("rst_ic_valid", {31'b0, bus.ic_valid}, 32'd0);
    chk("rst_cc_valid", {31'b0, bus.cc_valid}, 32'd0);
    chk("rst_fill_valid", {31'b0, bus.cc_fill_valid}, 32'd0);
    chk("rst_proc_rdata", bus.proc_rdata, 32'd0);
    chk("rst_fill_data", {16'b0, bus.cc_fill_data}, 32'd0);
    chk_counters();
    resetn = 1'b1;

    // Reset while the icache request is outstanding
    @(negedge clk);
    bus.cc_hit = 1'b0;
    ic_wait = 1000;
    bus.proc_addr = 32'h300;
    bus.proc_valid = 1'b1;
    @(negedge clk);
    bus.proc_valid = 1'b0;
    n = 0;
    while (!bus.ic_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t1_ic_valid_up", {31'b0, bus.ic_valid}, 32'd1);
    chk("t1_ic_addr", bus.ic_addr, 32'h300);
    #1;
    resetn = 1'b0;
    #1;
    chk("t1_ic_valid_in_rst", {31'b0, bus.ic_valid}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_hit = 0; m_fill = 0; m_nocomp = 0;
    ic_wait = 0;
    repeat (5) @(negedge clk);
    chk("t1_ic_valid_after", {31'b0, bus.ic_valid}, 32'd0);
    chk("t1_cc_valid_after", {31'b0, bus.cc_valid}, 32'd0);
    chk("t1_resp_count", resp_cnt, 32'd0);
    chk("t1_fill_addr", bus.cc_fill_addr, 32'd0);

    for (int i = 0; i < 7; i++) apply(vecs[i]);

    // proc_valid held with a moving address: only addresses at accept edges count
    @(negedge clk);
    base = cyc;
    bus.cc_hit = 1'b1;
    bus.cc_rdata = {vecs[0].k3, vecs[0].k2, vecs[0].k1};
    for (int k = 0; k < 3; k++) begin
      e.addr = 32'h200 + 32'(12 * k);
      e.rdata = vecs[0].inst;
      e.hit = 1'b1;  e.fill = 1'b0;  e.fdata = '0;
      e.ev1 = '0;  e.ev2 = '0;  e.ev3 = '0;
      e.cyc = base + 2 + 3 * k;
      sb_q.push_back(e);
`ifdef COMP_FETCH_CTRL_STATS_EN
      m_hit = sat(m_hit);
`endif
    end
    n = resp_cnt + 3;
    for (int k = 0; k < 8; k++) begin
      bus.proc_addr = 32'h200 + 32'(4 * k);
      bus.proc_valid = (k < 7);
      @(negedge clk);
    end
    wait_resp(n);
    @(negedge clk);
    #1;
    chk("t5_queue_empty", sb_q.size(), 32'd0);
    chk_counters();

    // Long run of hits to drive cnt_cc_hit into saturation
    for (int i = 0; i < 20; i++) apply(vecs[5]);
    repeat (3) @(negedge clk);
    chk_counters();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
